// File: rtl/ti_adc_frame.sv
// ti_adc_frame: back-end for the time-interleaved SAR-ADC. It drives rotating sample strobes, captures each way's result and assembles frames.
// Optional macro TI_ADC_OFFSET_EN adds a per-way offset calibration port and saturating correction at capture.
module ti_adc_frame #(
  parameter int unsigned ADC_BITS = 9,
  parameter int unsigned ADC_WAYS = 8,
  parameter int unsigned CLK_INIT = 0,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                          adc_clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [$clog2(ADC_WAYS):0]     way_num,
  output logic [ADC_WAYS-1:0]           subadc_clk,
  input  logic [ADC_BITS*ADC_WAYS-1:0]  subadc_data,
  input  logic [ADC_WAYS-1:0]           subadc_compl,
`ifdef TI_ADC_OFFSET_EN
  input  logic                          cal_we,
  input  logic [$clog2(ADC_WAYS)-1:0]   cal_way,
  input  logic signed [ADC_BITS-1:0]    cal_offset,
`endif
  output logic [ADC_BITS*ADC_WAYS-1:0]  frame_data,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [CNT_BITS-1:0]           drop_cnt
);

  localparam int unsigned WAY_W   = $clog2(ADC_WAYS) + 1;
  localparam int unsigned FRAME_W = ADC_BITS * ADC_WAYS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [WAY_W-1:0]    n_reg;
  logic [WAY_W-1:0]    ptr;
  logic [ADC_WAYS-1:0] got;
  logic [ADC_BITS-1:0] staging [ADC_WAYS];

  logic [WAY_W-1:0]    n_start_c;
  logic [WAY_W-1:0]    ptr_start_c;
  logic [WAY_W-1:0]    ptr_next_c;
  logic                run_en_c;
  logic [ADC_WAYS-1:0] act_c;
  logic [ADC_WAYS-1:0] compl_act_c;
  logic [ADC_BITS-1:0] raw_c;
  logic [ADC_BITS-1:0] cap_c;
  logic [ADC_BITS-1:0] stage_next_c [ADC_WAYS];
  logic [FRAME_W-1:0]  frame_next_c;
  logic                frame_done_c;

`ifdef TI_ADC_OFFSET_EN
  logic signed [ADC_BITS-1:0] offset [ADC_WAYS];
  logic signed [ADC_BITS+1:0] sum_c;
`endif

  // Way w sits at bit ADC_WAYS-1-w, so way 0 is the MSB of the strobe vector.
  function automatic logic [ADC_WAYS-1:0] way_onehot(input logic [WAY_W-1:0] w);
    way_onehot = '0;
    for (int unsigned i = 0; i < ADC_WAYS; i++) begin
      if (32'(w) == i) way_onehot[ADC_WAYS-1-i] = 1'b1;
    end
  endfunction

  // Active way count, start pointer and rotation.
  always_comb begin
    n_start_c = way_num;
    if (way_num == '0 || 32'(way_num) > ADC_WAYS) n_start_c = WAY_W'(ADC_WAYS);
    ptr_start_c = (CLK_INIT < 32'(n_start_c)) ? WAY_W'(CLK_INIT) : '0;
    ptr_next_c  = (32'(ptr) + 32'd1 >= 32'(n_reg)) ? '0 : ptr + WAY_W'(1);
  end

  // Per-way capture, optional offset correction, and frame assembly.
  always_comb begin
    run_en_c     = (state == RUN) && en;
    act_c        = '0;
    compl_act_c  = '0;
    raw_c        = '0;
    cap_c        = '0;
    frame_next_c = '0;
`ifdef TI_ADC_OFFSET_EN
    sum_c        = '0;
`endif
    for (int unsigned i = 0; i < ADC_WAYS; i++) begin
      act_c[i]       = (i < 32'(n_reg));
      compl_act_c[i] = run_en_c && act_c[i] && subadc_compl[ADC_WAYS-1-i];
      raw_c          = subadc_data[(ADC_WAYS-1-i)*ADC_BITS +: ADC_BITS];
`ifdef TI_ADC_OFFSET_EN
      sum_c = $signed({2'b00, raw_c}) + $signed({{2{offset[i][ADC_BITS-1]}}, offset[i]});
      if (sum_c[ADC_BITS+1])     cap_c = '0;
      else if (sum_c[ADC_BITS])  cap_c = '1;
      else                       cap_c = sum_c[ADC_BITS-1:0];
`else
      cap_c = raw_c;
`endif
      stage_next_c[i] = compl_act_c[i] ? cap_c : staging[i];
      if (act_c[i]) frame_next_c[(ADC_WAYS-1-i)*ADC_BITS +: ADC_BITS] = stage_next_c[i];
    end
    frame_done_c = run_en_c && (((got | compl_act_c) & act_c) == act_c);
  end

  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      n_reg       <= '0;
      ptr         <= '0;
      got         <= '0;
      subadc_clk  <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      drop_cnt    <= '0;
      for (int unsigned i = 0; i < ADC_WAYS; i++) staging[i] <= '0;
`ifdef TI_ADC_OFFSET_EN
      for (int unsigned i = 0; i < ADC_WAYS; i++) offset[i] <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state      <= RUN;
            n_reg      <= n_start_c;
            ptr        <= ptr_start_c;
            subadc_clk <= way_onehot(ptr_start_c);
          end
        end
        RUN: begin
          if (!en) begin
            state      <= IDLE;
            subadc_clk <= '0;
            got        <= '0;
          end else begin
            ptr        <= ptr_next_c;
            subadc_clk <= way_onehot(ptr_next_c);
            got        <= frame_done_c ? '0 : (got | compl_act_c);
            for (int unsigned i = 0; i < ADC_WAYS; i++) staging[i] <= stage_next_c[i];
          end
        end
        default: state <= IDLE;
      endcase

      // Output register: load on completion if free or draining, else count a drop.
      if (frame_done_c) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= frame_next_c;
          frame_valid <= 1'b1;
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + CNT_BITS'(1);
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

`ifdef TI_ADC_OFFSET_EN
      if (cal_we && 32'(cal_way) < ADC_WAYS) offset[cal_way] <= cal_offset;
`endif
    end
  end

endmodule

// File: tb/tb_ti_adc_frame.sv
// tb_ti_adc_frame: randomized + directed bench for ti_adc_frame against a cycle-level reference model.
// Two instances share stimulus: CLK_INIT=0 (fully checked) and CLK_INIT=5 (strobe sequence checked).
module tb_ti_adc_frame;
  localparam int B = 9;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [3:0]     way_num;
  logic [W-1:0]   compl;
  logic [W*B-1:0] data;
  logic           frame_ready;
  logic [W-1:0]   sclk0, sclk5;
  logic [W*B-1:0] fd0, fd5;
  logic           fv0, fv5;
  logic [15:0]    dc0, dc5;
`ifdef TI_ADC_OFFSET_EN
  logic           cal_we;
  logic [2:0]     cal_way;
  logic signed [B-1:0] cal_offset;
`endif

  ti_adc_frame #(.ADC_BITS(B), .ADC_WAYS(W), .CLK_INIT(0), .CNT_BITS(16)) u_dut (
    .adc_clk(clk), .rst_n(rst_n), .en(en), .way_num(way_num), .subadc_clk(sclk0),
    .subadc_data(data), .subadc_compl(compl),
`ifdef TI_ADC_OFFSET_EN
    .cal_we(cal_we), .cal_way(cal_way), .cal_offset(cal_offset),
`endif
    .frame_data(fd0), .frame_valid(fv0), .frame_ready(frame_ready), .drop_cnt(dc0));

  ti_adc_frame #(.ADC_BITS(B), .ADC_WAYS(W), .CLK_INIT(5), .CNT_BITS(16)) u_dut5 (
    .adc_clk(clk), .rst_n(rst_n), .en(en), .way_num(way_num), .subadc_clk(sclk5),
    .subadc_data(data), .subadc_compl(compl),
`ifdef TI_ADC_OFFSET_EN
    .cal_we(cal_we), .cal_way(cal_way), .cal_offset(cal_offset),
`endif
    .frame_data(fd5), .frame_valid(fv5), .frame_ready(frame_ready), .drop_cnt(dc5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: way-indexed arrays, strobe position derived from cycles since start.
  bit m_live = 0;
  bit m_run  = 0;
  int m_n    = W;
  int m_k    = 0;
  bit m_got   [W];
  int m_stage [W];
  int m_frame [W];
  int m_off   [W];
  bit m_valid = 0;
  int m_drop  = 0;

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > (1 << B) - 1) return (1 << B) - 1;
    return v;
  endfunction

  function automatic logic [W-1:0] exp_strobe(input int init);
    int way;
    if (!m_run) return '0;
    way = ((init < m_n ? init : 0) + m_k) % m_n;
    return 8'h80 >> way;
  endfunction

  function automatic logic [W*B-1:0] model_frame();
    logic [W*B-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) v[(W-1-i)*B +: B] = 9'(m_frame[i]);
    return v;
  endfunction

  function automatic logic [W*B-1:0] put(input logic [W*B-1:0] v, input int way, input int val);
    logic [W*B-1:0] r;
    r = v;
    r[(W-1-way)*B +: B] = 9'(val);
    return r;
  endfunction

  always @(posedge clk) begin : model
    bit loaded, accept, all;
    int nn;
    m_live = 1;
    if (!rst_n) begin
      m_run = 0; m_k = 0; m_valid = 0; m_drop = 0;
      for (int i = 0; i < W; i++) begin
        m_got[i] = 0; m_stage[i] = 0; m_frame[i] = 0; m_off[i] = 0;
      end
    end else begin
      accept = m_valid && frame_ready;
      loaded = 0;
      if (!m_run) begin
        if (en) begin
          nn = int'(way_num);
          if (nn == 0 || nn > W) nn = W;
          m_n = nn; m_k = 0; m_run = 1;
        end
      end else if (!en) begin
        m_run = 0;
        for (int i = 0; i < W; i++) m_got[i] = 0;
      end else begin
        m_k++;
        for (int i = 0; i < m_n; i++) begin
          if (compl[W-1-i]) begin
            m_stage[i] = sat(int'(data[(W-1-i)*B +: B]) + m_off[i]);
            m_got[i] = 1;
          end
        end
        all = 1;
        for (int i = 0; i < m_n; i++) if (!m_got[i]) all = 0;
        if (all) begin
          for (int i = 0; i < W; i++) m_got[i] = 0;
          if (!m_valid || frame_ready) begin
            for (int i = 0; i < W; i++) m_frame[i] = (i < m_n) ? m_stage[i] : 0;
            m_valid = 1;
            loaded = 1;
          end else if (m_drop < 65535) begin
            m_drop++;
          end
        end
      end
      if (accept && !loaded) m_valid = 0;
`ifdef TI_ADC_OFFSET_EN
      if (cal_we) m_off[cal_way] = int'(cal_offset);
`endif
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("strobe", 128'(sclk0), 128'(exp_strobe(0)));
      check("strobe_init5", 128'(sclk5), 128'(exp_strobe(5)));
      check("valid", 128'(fv0), 128'(m_valid));
      check("frame", 128'(fd0), 128'(model_frame()));
      check("drop", 128'(dc0), 128'(m_drop));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [3:0] n);
    en = 1'b0; compl = '0;
    tick();
    way_num = n; en = 1'b1;
    tick();
  endtask

  logic [W*B-1:0] exp_f;

  initial begin
    rst_n = 1'b0; en = 1'b0; way_num = 4'd8; compl = '0; data = '0; frame_ready = 1'b1;
`ifdef TI_ADC_OFFSET_EN
    cal_we = 1'b0; cal_way = '0; cal_offset = '0;
`endif
    tick();
    tick();
    check("rst_strobe", 128'(sclk0), 128'(0));
    check("rst_valid", 128'(fv0), 128'(0));
    check("rst_frame", 128'(fd0), 128'(0));
    check("rst_drop", 128'(dc0), 128'(0));

    // Start and full eight-way frame
    rst_n = 1'b1; en = 1'b1;
    tick();
    check("start_strobe", 128'(sclk0), 128'(8'h80));
    exp_f = '0;
    for (int i = 0; i < W; i++) begin
      compl = 8'h80 >> i;
      data = put(data, i, i * 16);
      exp_f = put(exp_f, i, i * 16);
      tick();
      if (i < W - 1) check("full_early_valid", 128'(fv0), 128'(0));
    end
    check("full_valid", 128'(fv0), 128'(1));
    check("full_frame", 128'(fd0), 128'(exp_f));
    compl = '0;
    tick();
    check("full_valid_fall", 128'(fv0), 128'(0));

    // Three ways with CLK_INIT=5 falling back to way 0; way 6 complete ignored
    restart(4'd3);
    exp_f = '0;
    for (int k = 0; k < 3; k++) begin
      check("reduced_strobe", 128'(sclk5), 128'(8'h80 >> k));
      compl = (8'h80 >> k) | 8'h02;
      data = put(data, k, 100 + k);
      data = put(data, 6, 77);
      exp_f = put(exp_f, k, 100 + k);
      tick();
    end
    check("reduced_wrap", 128'(sclk5), 128'(8'h80));
    check("reduced_frame", 128'(fd0), 128'(exp_f));
    compl = '0;
    tick();

    // Backpressure: first frame held, three more dropped
    frame_ready = 1'b0;
    exp_f = '0;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 3; k++) begin
        compl = 8'h80 >> k;
        data = put(data, k, 10 * f + k);
        if (f == 0) exp_f = put(exp_f, k, k);
        tick();
      end
    end
    compl = '0;
    tick();
    check("bp_drop", 128'(dc0), 128'(3));
    check("bp_frame", 128'(fd0), 128'(exp_f));
    check("bp_valid", 128'(fv0), 128'(1));
    frame_ready = 1'b1;
    tick();
    check("bp_accept", 128'(fv0), 128'(0));

    // Abort a partial frame, then a clean frame after restart
    restart(4'd8);
    for (int i = 0; i < 4; i++) begin
      compl = 8'h80 >> i;
      data = put(data, i, 50 + i);
      tick();
    end
    restart(4'd8);
    exp_f = '0;
    for (int i = 0; i < W; i++) begin
      compl = 8'h80 >> i;
      data = put(data, i, 300 + i);
      exp_f = put(exp_f, i, 300 + i);
      tick();
      if (i < W - 1) check("abort_no_early", 128'(fv0), 128'(0));
    end
    check("abort_frame", 128'(fd0), 128'(exp_f));
    compl = '0;
    tick();

`ifdef TI_ADC_OFFSET_EN
    // Offset correction with saturation at both ends
    restart(4'd3);
    cal_we = 1'b1; cal_way = 3'd2; cal_offset = -9'sd5;
    tick();
    cal_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      compl = 8'h80 >> k;
      data = put(data, k, (k == 2) ? 3 : 7 + k);
      tick();
    end
    exp_f = put(put(put('0, 0, 7), 1, 8), 2, 0);
    check("off_neg_sat", 128'(fd0), 128'(exp_f));
    cal_we = 1'b1; cal_way = 3'd2; cal_offset = 9'sd10;
    compl = '0;
    tick();
    cal_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      compl = 8'h80 >> k;
      data = put(data, k, (k == 2) ? 509 : 20 + k);
      tick();
    end
    exp_f = put(put(put('0, 0, 20), 1, 21), 2, 511);
    check("off_pos_sat", 128'(fd0), 128'(exp_f));
    compl = '0;
    tick();
`endif

    // Randomized traffic with occasional stop/start and a mid-run reset
    for (int c = 0; c < 3000; c++) begin
      rst_n = (c != 1500);
      en = ($urandom_range(0, 99) < 97);
      way_num = 4'($urandom_range(0, 15));
      compl = 8'($urandom & $urandom);
      data = 72'({$urandom, $urandom, $urandom});
      frame_ready = (c < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
`ifdef TI_ADC_OFFSET_EN
      cal_we = ($urandom_range(0, 15) == 0);
      cal_way = 3'($urandom_range(0, 7));
      cal_offset = 9'($urandom);
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
